// File: rtl/ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_cp_remover
// Description : Aligns to each detected frame (sof) and removes the cyclic
//               prefix from every OFDM symbol. It forwards exactly fft_len
//               samples per symbol and flags the last one with o_tlast.
//               Output goes through a registered stage with a one-entry skid
//               buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_cp_remover #(
  parameter int SR_CP_LEN       = 132,
  parameter int SR_FFT_LEN      = 133,
  parameter int SR_NUM_SYMBOLS  = 134,
  parameter int DEFAULT_CP_LEN  = 16,
  parameter int DEFAULT_FFT_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic        sof,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] o_sym_idx,
  output logic [15:0] dropped_sof
);

  localparam logic [7:0]  ADDR_CP   = 8'(SR_CP_LEN);
  localparam logic [7:0]  ADDR_FFT  = 8'(SR_FFT_LEN);
  localparam logic [7:0]  ADDR_NSYM = 8'(SR_NUM_SYMBOLS);
  localparam logic [15:0] CP_RST    = 16'(DEFAULT_CP_LEN);
  localparam logic [15:0] FFT_RST   = 16'(DEFAULT_FFT_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_SYM  = 2'd2
  } state_t;

  // Framing comes from the counters, so the upstream tlast and the upper
  // settings bits are not used.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_tlast, set_data[31:16]};

  // Live settings registers
  logic [15:0] cp_len, fft_len, num_sym;
  // Per-frame shadow copies
  logic [15:0] sh_cp, sh_fft, sh_num;
  logic [15:0] sh_cp_nxt, sh_fft_nxt, sh_num_nxt;

  state_t      state, state_nxt;
  logic [15:0] cp_cnt, cp_cnt_nxt;
  logic [15:0] smp_cnt, smp_cnt_nxt;
  logic [15:0] sym_cnt, sym_cnt_nxt;

  // Skid buffer entry
  logic [31:0] skid_data;
  logic        skid_last;
  logic [15:0] skid_idx;
  logic        skid_valid;

  // Per-beat decode results
  logic        beat;
  logic        honour;
  logic        do_cp, do_sym;
  logic [15:0] eff_cp, eff_fft, eff_num, eff_sym, cur_cnt;
  logic [15:0] fft_live_fix;
  logic        push, push_last, drop;
  logic [15:0] push_idx;
  logic        out_free;

  assign i_tready     = !skid_valid;
  assign beat         = i_tvalid && i_tready;
  assign fft_live_fix = (fft_len == 16'd0) ? 16'd1 : fft_len;
  assign out_free     = !o_tvalid || o_tready;

  // Settings bus register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cp_len  <= CP_RST;
      fft_len <= FFT_RST;
      num_sym <= 16'd0;
    end else if (set_stb) begin
      if (set_addr == ADDR_CP)   cp_len  <= set_data[15:0];
      if (set_addr == ADDR_FFT)  fft_len <= set_data[15:0];
      if (set_addr == ADDR_NSYM) num_sym <= set_data[15:0];
    end
  end

  // FSM state, counters and shadow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cp_cnt  <= 16'd0;
      smp_cnt <= 16'd0;
      sym_cnt <= 16'd0;
      sh_cp   <= 16'd0;
      sh_fft  <= 16'd1;
      sh_num  <= 16'd0;
    end else begin
      state   <= state_nxt;
      cp_cnt  <= cp_cnt_nxt;
      smp_cnt <= smp_cnt_nxt;
      sym_cnt <= sym_cnt_nxt;
      sh_cp   <= sh_cp_nxt;
      sh_fft  <= sh_fft_nxt;
      sh_num  <= sh_num_nxt;
    end
  end

  // Next-state logic: decides whether a beat is discarded as CP, forwarded
  // as a symbol sample, or (re)starts a frame with freshly latched settings.
  always_comb begin
    state_nxt   = state;
    cp_cnt_nxt  = cp_cnt;
    smp_cnt_nxt = smp_cnt;
    sym_cnt_nxt = sym_cnt;
    sh_cp_nxt   = sh_cp;
    sh_fft_nxt  = sh_fft;
    sh_num_nxt  = sh_num;
    push        = 1'b0;
    push_last   = 1'b0;
    push_idx    = sym_cnt;
    drop        = 1'b0;
    honour      = 1'b0;
    do_cp       = 1'b0;
    do_sym      = 1'b0;
    eff_cp      = sh_cp;
    eff_fft     = sh_fft;
    eff_num     = sh_num;
    eff_sym     = sym_cnt;
    cur_cnt     = 16'd0;

    if (clear) begin
      state_nxt   = ST_IDLE;
      cp_cnt_nxt  = 16'd0;
      smp_cnt_nxt = 16'd0;
      sym_cnt_nxt = 16'd0;
    end else if (beat) begin
      // A frame may start in IDLE or on the first beat of a CP period
      honour = sof && ((state == ST_IDLE) ||
                       ((state == ST_CP) && (cp_cnt == 16'd0)));
      drop   = sof && !honour;

      if (honour) begin
        eff_cp     = cp_len;
        eff_fft    = fft_live_fix;
        eff_num    = num_sym;
        eff_sym    = 16'd0;
        sh_cp_nxt  = cp_len;
        sh_fft_nxt = fft_live_fix;
        sh_num_nxt = num_sym;
        sym_cnt_nxt = 16'd0;
        if (cp_len != 16'd0) do_cp = 1'b1;
        else                 do_sym = 1'b1;
        cur_cnt = 16'd0;
      end else begin
        case (state)
          ST_CP: begin
            do_cp   = 1'b1;
            cur_cnt = cp_cnt;
          end
          ST_SYM: begin
            do_sym  = 1'b1;
            cur_cnt = smp_cnt;
          end
          default: ;
        endcase
      end

      if (do_cp) begin
        if (cur_cnt == eff_cp - 16'd1) begin
          state_nxt   = ST_SYM;
          smp_cnt_nxt = 16'd0;
        end else begin
          state_nxt  = ST_CP;
          cp_cnt_nxt = cur_cnt + 16'd1;
        end
      end

      if (do_sym) begin
        push      = 1'b1;
        push_idx  = eff_sym;
        push_last = (cur_cnt == eff_fft - 16'd1);
        if (push_last) begin
          sym_cnt_nxt = eff_sym + 16'd1;
          smp_cnt_nxt = 16'd0;
          if ((eff_num != 16'd0) && (eff_sym + 16'd1 == eff_num)) begin
            state_nxt = ST_IDLE;
          end else if (eff_cp == 16'd0) begin
            state_nxt = ST_SYM;
          end else begin
            state_nxt  = ST_CP;
            cp_cnt_nxt = 16'd0;
          end
        end else begin
          state_nxt   = ST_SYM;
          smp_cnt_nxt = cur_cnt + 16'd1;
        end
      end
    end
  end

  // Output register plus skid entry; the skid only fills when the output
  // register is held by back-pressure, so nothing is lost or duplicated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tdata    <= 32'd0;
      o_tlast    <= 1'b0;
      o_tvalid   <= 1'b0;
      o_sym_idx  <= 16'd0;
      skid_data  <= 32'd0;
      skid_last  <= 1'b0;
      skid_idx   <= 16'd0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (o_tready) begin
        o_tdata    <= skid_data;
        o_tlast    <= skid_last;
        o_sym_idx  <= skid_idx;
        o_tvalid   <= 1'b1;
        skid_valid <= 1'b0;
      end
    end else if (push) begin
      if (out_free) begin
        o_tdata   <= i_tdata;
        o_tlast   <= push_last;
        o_sym_idx <= push_idx;
        o_tvalid  <= 1'b1;
      end else begin
        skid_data  <= i_tdata;
        skid_last  <= push_last;
        skid_idx   <= push_idx;
        skid_valid <= 1'b1;
      end
    end else if (out_free) begin
      // Symbol index moves on once the tlast beat has left the output
      if (o_tvalid && o_tlast) o_sym_idx <= o_sym_idx + 16'd1;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end
  end

  // Saturating count of ignored sof pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_sof <= 16'd0;
    end else if (drop && (dropped_sof != 16'hFFFF)) begin
      dropped_sof <= dropped_sof + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofdm_cp_remover
// Description : Directed self-checking bench for ofdm_cp_remover.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofdm_cp_remover;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic        sof;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [15:0] o_sym_idx;
  logic [15:0] dropped_sof;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;
  logic rnd    = 1'b0;
  logic hold   = 1'b0;
  logic [48:0] expq[$];

  ofdm_cp_remover dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(i_tready), .sof(sof),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .o_sym_idx(o_sym_idx), .dropped_sof(dropped_sof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l, input logic [15:0] idx);
    expq.push_back({l, idx, d});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    i_tvalid = 1'b0;
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    int n;
    n = 0;
    i_tdata  = d;
    sof      = s;
    i_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!i_tready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_tvalid = 1'b0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", expq.size(), 32'd0);
  endtask

  // Output ready pattern: held low, random, or always high
  always @(posedge clk) begin
    #1;
    if (hold)     o_tready = 1'b0;
    else if (rnd) o_tready = 1'($urandom_range(0, 1));
    else          o_tready = 1'b1;
  end

  // Output monitor against the expected-beat queue
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (o_tvalid && o_tready) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", o_tdata, 32'hFFFF_FFFF);
        end else begin
          logic [48:0] e;
          e = expq.pop_front();
          check("data", o_tdata, e[31:0]);
          check("tlast", {31'd0, o_tlast}, {31'd0, e[48]});
          check("sym_idx", {16'd0, o_sym_idx}, {16'd0, e[47:32]});
        end
      end
      if (!i_tready) check("skid_full", {31'd0, o_tvalid}, 32'd1);
      if (!rnd && !hold) check("itready_free", {31'd0, i_tready}, 32'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0;
    set_data = 32'd0; i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0;
    sof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, o_tlast}, 32'd0);
    check("rst_tdata", o_tdata, 32'd0);
    check("rst_idx", {16'd0, o_sym_idx}, 32'd0);
    check("rst_drop", {16'd0, dropped_sof}, 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // Defaults cp=16 fft=64, two symbols per frame
    wr(8'd134, 32'd2);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 64; k++) push_exp(16 + s * 80 + k, k == 63, 16'(s));
    for (int k = 0; k < 180; k++) send(k, k == 0);
    drain();
    check("s1_drop", {16'd0, dropped_sof}, 32'd0);

    // Same frame under random back-pressure
    rnd = 1'b1;
    idle(2);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 64; k++) push_exp(16 + s * 80 + k, k == 63, 16'(s));
    for (int k = 0; k < 170; k++) send(k, k == 0);
    drain();
    rnd = 1'b0;
    idle(3);

    // No CP, 4-sample symbols, unlimited symbols
    wr(8'd132, 32'd0);
    wr(8'd133, 32'd4);
    wr(8'd134, 32'd0);
    for (int k = 0; k < 12; k++) push_exp(1000 + k, (k % 4) == 3, 16'(k / 4));
    for (int k = 0; k < 12; k++) send(1000 + k, k == 0);
    drain();

    // Clear returns to IDLE: plain beats afterwards are discarded
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 0; k < 3; k++) send(1500 + k, 1'b0);
    idle(4);
    check("clear_quiet", {31'd0, o_tvalid}, 32'd0);

    // Ignored sof mid-symbol, restart on the next boundary with new fft_len
    wr(8'd132, 32'd4);
    wr(8'd133, 32'd16);
    wr(8'd134, 32'd3);
    for (int k = 4; k < 20; k++) push_exp(2000 + k, k == 19, 16'd0);
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++) push_exp(2024 + s * 12 + k, k == 7, 16'(s));
    for (int k = 0; k < 60; k++) begin
      if (k == 6) wr(8'd133, 32'd8);
      send(2000 + k, (k == 0) || (k == 14) || (k == 20));
    end
    drain();
    check("s5_drop", {16'd0, dropped_sof}, 32'd1);

    // Async reset with a beat held in the output and one in the skid
    hold = 1'b1;
    idle(2);
    for (int k = 0; k < 6; k++) send(3000 + k, k == 0);
    idle(1);
    @(negedge clk);
    check("pre_rst_tvalid", {31'd0, o_tvalid}, 32'd1);
    check("pre_rst_tdata", o_tdata, 32'd3004);
    check("pre_rst_itready", {31'd0, i_tready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("mid_rst_tdata", o_tdata, 32'd0);
    check("mid_rst_drop", {16'd0, dropped_sof}, 32'd0);
    check("mid_rst_itready", {31'd0, i_tready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    hold  = 1'b0;
    idle(2);

    // Defaults restored: cp=16, fft=64, unlimited
    for (int k = 16; k < 19; k++) push_exp(4000 + k, 1'b0, 16'd0);
    for (int k = 0; k < 19; k++) send(4000 + k, k == 0);
    drain();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    idle(3);
    check("end_queue", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ofdm_cp_remover.md
Name: ofdm_cp_remover

Overview:
- Sits directly downstream of the Schmidl-Cox detector, in the same AXI-wrapper user-code region; consumes its 32-bit IQ stream and sof flag.
- Aligns to each detected frame, strips the cyclic prefix from every OFDM symbol and forwards exactly fft_len samples per symbol, with tlast on the last sample.
- Produces FFT-ready packets for a downstream FFT.
- Configured over the settings bus.

Parameters:
- SR_CP_LEN, 132, settings address of the CP length register (bits [15:0]).
- SR_FFT_LEN, 133, settings address of the FFT length register (bits [15:0]).
- SR_NUM_SYMBOLS, 134, settings address of symbols-per-frame (bits [15:0]); 0 = unlimited.
- DEFAULT_CP_LEN, 16, reset value of cp_len.
- DEFAULT_FFT_LEN, 64, reset value of fft_len.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear: returns the FSM to IDLE; settings are kept.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  32  IQ sample, I in [31:16], Q in [15:0].
- i_tlast  in  1  ignored; framing comes from the counters.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- sof  in  1  start of frame; qualified by i_tvalid&&i_tready.
- o_tdata  out  32  IQ sample.
- o_tlast  out  1  last sample of a symbol.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- o_sym_idx  out  16  index of the current output symbol within the frame, starting at 0.
- dropped_sof  out  16  saturating count of sof pulses that were ignored.

Behaviour:
- Reset (async): FSM=IDLE; all counters 0; o_tvalid=0, o_tlast=0, o_tdata=0, o_sym_idx=0, dropped_sof=0.
- Registers: cp_len=DEFAULT_CP_LEN, fft_len=DEFAULT_FFT_LEN, num_sym=0. Written on set_stb when set_addr matches.
- Shadowing: live registers are copied to shadows only on the accepted sof beat that starts a frame. Writes mid-frame do not affect the current frame.
- fft_len shadow of 0 is forced to 1.
- "beat" = i_tvalid&&i_tready.
- Output stage: one register stage with a skid buffer.
  - Accepted SYM beats appear at o_tdata one cycle later.
  - i_tready deasserts only when the skid buffer is full.
  - Full throughput at o_tready=1; no beat is lost or duplicated under back-pressure.
- IDLE: i_tready=1; beats are discarded.
  - A beat with sof: latch shadows; sym_cnt=0.
  - cp_len>0: go to CP. The sof beat is CP sample 0, so cp_cnt=1. If cp_len==1, go straight to SYM.
  - cp_len==0: go to SYM. The sof beat is output sample 0.
- CP: i_tready=1; beats are discarded; cp_cnt increments.
  - At cp_cnt==cp_len-1 on a beat: go to SYM with smp_cnt=0.
- SYM: beats are forwarded; smp_cnt increments.
  - The beat with smp_cnt==fft_len-1 carries o_tlast=1.
  - On that beat: sym_cnt++ and o_sym_idx advances after that beat leaves the output.
  - If num_sym!=0 and sym_cnt+1==num_sym: go to IDLE.
  - Otherwise: go to CP, or stay in SYM with smp_cnt=0 if cp_len==0.
- sof handling:
  - Honoured in IDLE.
  - Honoured on the first beat of a CP period, i.e. a symbol boundary. There it restarts the frame: shadows relatch, sym_cnt=0, and the beat counts as CP sample 0.
  - sof on any other beat is ignored and dropped_sof increments, saturating at 16'hFFFF.
- clear: FSM goes to IDLE next cycle.
  - An output beat already registered still drains.
  - The partial symbol is not completed, so no tlast is generated.
- Counters are 16 bits. Comparisons use the shadowed values, so there is no wrap within valid settings.
- Reset mid-frame: immediate return to reset state; a held output beat is lost.

Test Plan:
- Defaults (cp=16, fft=64, num_sym=2); sof on beat 0 of a 160-sample ramp 0..159.
  - Output samples 16..79 (tlast on 79, idx 0), then 96..159 (tlast on 159, idx 1).
  - Then IDLE; further samples are dropped.
- cp_len=0, fft_len=4, num_sym=0; sof on beat 0.
  - Continuous 4-sample packets with tlast every 4th sample; o_sym_idx counts 0,1,2,…
- Random o_tready (50%) on the first scenario.
  - Identical output sequence; no gaps in data values.
  - i_tready drops only when the skid buffer is full.
- sof on SYM sample 10, then sof at the next symbol boundary.
  - First sof ignored, dropped_sof=1.
  - Second sof restarts the frame: o_sym_idx=0; shadows take any new settings.
- Write fft_len=32 mid-frame.
  - Current frame keeps 64-sample symbols; the next frame after sof uses 32.
- Assert reset during SYM, and separately pulse clear.
  - reset: outputs return to 0 immediately.
  - clear: FSM is in IDLE next cycle; the next sof gives a clean frame.
